// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the binary-to-BCD converter:
//   - bcd_state_t : converter FSM state type (IDLE / SHIFT)
//   - BCD_DIGIT_W : width of one BCD digit
//   - bcd_clog2() : ceiling log2, used to size the bit counter at elaboration
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } bcd_state_t;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int bcd_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble correction for a single BCD digit: adds 3 when the digit is
// 5 or more, so the following left shift carries correctly into the next
// decimal digit.
// Ports:
//   digit_in  [3:0] : digit before correction
//   digit_out [3:0] : corrected digit (digit_in + 3 if digit_in >= 5)
// -----------------------------------------------------------------------------
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bcd_convert_module.sv
// -----------------------------------------------------------------------------
// bcd_convert_module
// Iterative binary-to-BCD converter (double dabble), one input bit per clock,
// MSB first. A conversion takes DATA_W clocks; results are registered only at
// completion so the outputs never show intermediate accumulator values.
// Ports:
//   CLK         : clock, rising edge
//   RST         : synchronous active-high reset
//   Start_Sig   : start request, sampled only while idle
//   Number_Data : unsigned binary input, captured on the accepting edge
//   Busy        : high while shifting
//   Done_Sig    : one-cycle completion pulse
//   Bcd_Data    : BCD result, digit 0 (ones) in the low nibble
//   Overflow    : value did not fit in DIGITS decimal digits (result saturated)
//   Digit_Blank : leading-zero blank mask, bit 0 never set
// -----------------------------------------------------------------------------
module bcd_convert_module
  import bcd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Start_Sig,
  input  logic [DATA_W-1:0]             Number_Data,
  output logic                          Busy,
  output logic                          Done_Sig,
  output logic [BCD_DIGIT_W*DIGITS-1:0] Bcd_Data,
  output logic                          Overflow,
  output logic [DIGITS-1:0]             Digit_Blank
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = bcd_clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [ACC_W-1:0] ALL_NINES = {DIGITS{4'd9}};
  // Reset blank mask: every digit blanked except the ones digit.
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  bcd_state_t        state_reg, state_next;
  logic [DATA_W-1:0] sr_reg, sr_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic              ovf_reg, ovf_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic [ACC_W-1:0]  bcd_out_reg, bcd_out_next;
  logic              ovf_out_reg, ovf_out_next;
  logic [DIGITS-1:0] blank_out_reg, blank_out_next;
  logic              done_reg, done_next;

  logic [ACC_W-1:0]  adj_acc;
  logic [ACC_W-1:0]  shifted_acc;
  logic              shifted_ovf;
  logic [DIGITS-1:0] blank_calc;

  // Per-digit +3 correction ahead of the shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_in  (acc_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_out (adj_acc[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Accumulator and overflow state as they will be after this shift edge.
  // A 1 leaving the top digit means the running value reached 10**DIGITS;
  // the value only grows from there, so the flag is sticky.
  assign shifted_acc = {adj_acc[ACC_W-2:0], sr_reg[DATA_W-1]};
  assign shifted_ovf = ovf_reg | adj_acc[ACC_W-1];

  // Blank digit i when it and every more significant digit are zero.
  assign blank_calc[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign blank_calc[gi] = (shifted_acc[ACC_W-1:gi*BCD_DIGIT_W] == '0);
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    sr_next        = sr_reg;
    acc_next       = acc_reg;
    ovf_next       = ovf_reg;
    cnt_next       = cnt_reg;
    bcd_out_next   = bcd_out_reg;
    ovf_out_next   = ovf_out_reg;
    blank_out_next = blank_out_reg;
    done_next      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (Start_Sig) begin
          sr_next    = Number_Data;
          acc_next   = '0;
          ovf_next   = 1'b0;
          cnt_next   = '0;
          state_next = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        sr_next  = {sr_reg[DATA_W-2:0], 1'b0};
        acc_next = shifted_acc;
        ovf_next = shifted_ovf;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_CNT) begin
          // Final shift: publish the result and return to idle, so a start
          // presented during the Done_Sig cycle is accepted immediately.
          state_next     = ST_IDLE;
          done_next      = 1'b1;
          ovf_out_next   = shifted_ovf;
          bcd_out_next   = shifted_ovf ? ALL_NINES : shifted_acc;
          blank_out_next = shifted_ovf ? '0 : blank_calc;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      sr_reg        <= '0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      cnt_reg       <= '0;
      bcd_out_reg   <= '0;
      ovf_out_reg   <= 1'b0;
      blank_out_reg <= BLANK_RST;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sr_reg        <= sr_next;
      acc_reg       <= acc_next;
      ovf_reg       <= ovf_next;
      cnt_reg       <= cnt_next;
      bcd_out_reg   <= bcd_out_next;
      ovf_out_reg   <= ovf_out_next;
      blank_out_reg <= blank_out_next;
      done_reg      <= done_next;
    end
  end

  assign Busy        = (state_reg == ST_SHIFT);
  assign Done_Sig    = done_reg;
  assign Bcd_Data    = bcd_out_reg;
  assign Overflow    = ovf_out_reg;
  assign Digit_Blank = blank_out_reg;

endmodule

// File: tb/tb_bcd_convert_module.sv
// -----------------------------------------------------------------------------
// tb_bcd_convert_module
// Three converter instances: (DATA_W,DIGITS) = (8,3), (8,2), (16,5).
// Stimulus pushes expected results (from a decimal-arithmetic model) into a
// scoreboard; a negedge monitor pops and compares on every Done_Sig.
// -----------------------------------------------------------------------------
module tb_bcd_convert_module;

  localparam int NI = 3;

  typedef struct packed {
    logic [1:0]  id;
    logic [39:0] bcd;
    logic        ovf;
    logic [9:0]  blank;
    logic [63:0] accept;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_at_edge = 1'b1;
  logic [63:0] cyc = 64'd0;

  always #5 clk = ~clk;

  logic        start_v [NI];
  logic [31:0] data_v  [NI];
  logic        busy_v  [NI];
  logic        done_v  [NI];
  logic        ovf_v   [NI];
  logic [39:0] bcd_v   [NI];
  logic [9:0]  blank_v [NI];

  logic [39:0] last_bcd   [NI];
  logic        last_ovf   [NI];
  logic [9:0]  last_blank [NI];

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] bcd_a;   logic [2:0] blank_a;
  logic [7:0]  bcd_b;   logic [1:0] blank_b;
  logic [19:0] bcd_c;   logic [4:0] blank_c;

  bcd_convert_module #(.DATA_W(8), .DIGITS(3)) u_a (
    .CLK(clk), .RST(rst), .Start_Sig(start_v[0]), .Number_Data(data_v[0][7:0]),
    .Busy(busy_v[0]), .Done_Sig(done_v[0]), .Bcd_Data(bcd_a),
    .Overflow(ovf_v[0]), .Digit_Blank(blank_a)
  );
  bcd_convert_module #(.DATA_W(8), .DIGITS(2)) u_b (
    .CLK(clk), .RST(rst), .Start_Sig(start_v[1]), .Number_Data(data_v[1][7:0]),
    .Busy(busy_v[1]), .Done_Sig(done_v[1]), .Bcd_Data(bcd_b),
    .Overflow(ovf_v[1]), .Digit_Blank(blank_b)
  );
  bcd_convert_module #(.DATA_W(16), .DIGITS(5)) u_c (
    .CLK(clk), .RST(rst), .Start_Sig(start_v[2]), .Number_Data(data_v[2][15:0]),
    .Busy(busy_v[2]), .Done_Sig(done_v[2]), .Bcd_Data(bcd_c),
    .Overflow(ovf_v[2]), .Digit_Blank(blank_c)
  );

  assign bcd_v[0]   = {28'd0, bcd_a};
  assign bcd_v[1]   = {32'd0, bcd_b};
  assign bcd_v[2]   = {20'd0, bcd_c};
  assign blank_v[0] = {7'd0, blank_a};
  assign blank_v[1] = {8'd0, blank_b};
  assign blank_v[2] = {5'd0, blank_c};

  function automatic int w_of(input int k);
    return (k == 2) ? 16 : 8;
  endfunction

  function automatic int d_of(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 2 : 5);
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Reference: decimal digits by division; overflow if val >= 10**d;
  // digit i (i>=1) blanked iff val < 10**i.
  function automatic exp_t model(input int k, input logic [63:0] val);
    exp_t e;
    logic [63:0] v;
    int d;
    d = d_of(k);
    e = '0;
    e.id = 2'(k);
    e.ovf = (val >= pow10(d));
    if (e.ovf) begin
      for (int i = 0; i < d; i++) e.bcd[4*i +: 4] = 4'd9;
    end else begin
      v = val;
      for (int i = 0; i < d; i++) begin
        e.bcd[4*i +: 4] = 4'(v % 64'd10);
        v = v / 64'd10;
      end
      for (int i = 1; i < d; i++) e.blank[i] = (val < pow10(i));
    end
    return e;
  endfunction

  function automatic logic [9:0] reset_blank(input int k);
    return 10'(((1 << d_of(k)) - 1) & ~1);
  endfunction

  task automatic chk(input string name, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d actual=%0h expected=%0h", name, k, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 64'd1;
    rst_at_edge <= rst;
  end

  // Monitor: compare on Done_Sig, otherwise require outputs to hold.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (rst_at_edge) begin
        last_bcd[k] = bcd_v[k]; last_ovf[k] = ovf_v[k]; last_blank[k] = blank_v[k];
      end else if (done_v[k] === 1'b1) begin
        if (sb_q.size() == 0 || int'(sb_q[0].id) != k) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done inst=%0d actual=1 expected=0", k);
        end else begin
          e = sb_q.pop_front();
          chk("bcd", k, 64'(bcd_v[k]), 64'(e.bcd));
          chk("overflow", k, 64'(ovf_v[k]), 64'(e.ovf));
          chk("blank", k, 64'(blank_v[k]), 64'(e.blank));
          chk("latency", k, cyc, e.accept + 64'(w_of(k)));
          chk("busy_in_done", k, 64'(busy_v[k]), 64'd0);
        end
        last_bcd[k] = bcd_v[k]; last_ovf[k] = ovf_v[k]; last_blank[k] = blank_v[k];
      end else begin
        chk("hold_bcd", k, 64'(bcd_v[k]), 64'(last_bcd[k]));
        chk("hold_ovf", k, 64'(ovf_v[k]), 64'(last_ovf[k]));
        chk("hold_blank", k, 64'(blank_v[k]), 64'(last_blank[k]));
      end
    end
  end

  // Called at a negedge; the next posedge accepts the request.
  task automatic issue(input int k, input logic [63:0] val);
    exp_t e;
    e = model(k, val);
    e.accept = cyc + 64'd1;
    sb_q.push_back(e);
    start_v[k] = 1'b1;
    data_v[k]  = 32'(val);
    @(negedge clk);
    start_v[k] = 1'b0;
    data_v[k]  = $urandom;
    chk("busy_after_accept", k, 64'(busy_v[k]), 64'd1);
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (done_v[k] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", k, 64'(n < 200), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_values();
    for (int k = 0; k < NI; k++) begin
      chk("rst_busy", k, 64'(busy_v[k]), 64'd0);
      chk("rst_done", k, 64'(done_v[k]), 64'd0);
      chk("rst_bcd", k, 64'(bcd_v[k]), 64'd0);
      chk("rst_ovf", k, 64'(ovf_v[k]), 64'd0);
      chk("rst_blank", k, 64'(blank_v[k]), 64'(reset_blank(k)));
    end
  endtask

  initial begin
    logic [63:0] val;
    logic [63:0] mask;
    int r;
    for (int k = 0; k < NI; k++) begin
      start_v[k] = 1'b0;
      data_v[k]  = 32'd0;
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
    check_reset_values();

    // Directed cases: 255, 0, 7 back-to-back on (8,3); overflow on (8,2);
    // back-to-back 65535 then 1234 on (16,5).
    issue(0, 64'd255); wait_done(0); idle(1);
    issue(0, 64'd0);   wait_done(0);
    issue(0, 64'd7);   wait_done(0); idle(2);
    issue(1, 64'd200); wait_done(1); idle(2);
    issue(2, 64'd65535); wait_done(2);
    issue(2, 64'd1234);  wait_done(2); idle(2);

    // Start during busy (third busy cycle) with different data is ignored.
    issue(0, 64'd123);
    idle(1);
    start_v[0] = 1'b1;
    data_v[0]  = 32'd45;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0); idle(2);

    // Reset mid-conversion: no Done_Sig, outputs back to reset values.
    issue(0, 64'd99);
    idle(2);
    rst = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    check_reset_values();
    idle(20);

    // Reset wins over a simultaneous start.
    rst = 1'b1;
    start_v[0] = 1'b1;
    data_v[0]  = 32'd5;
    @(negedge clk);
    rst = 1'b0;
    start_v[0] = 1'b0;
    chk("rst_priority_busy", 0, 64'(busy_v[0]), 64'd0);
    idle(12);

    // Randomized, with boundary values and random back-to-back starts.
    for (int k = 0; k < NI; k++) begin
      mask = (64'd1 << w_of(k)) - 64'd1;
      repeat (25) begin
        r = $urandom_range(0, 9);
        val = 64'($urandom) & mask;
        if (r == 0) val = mask;
        else if (r == 1 && pow10(d_of(k)) - 64'd1 <= mask) val = pow10(d_of(k)) - 64'd1;
        else if (r == 2 && pow10(d_of(k)) <= mask) val = pow10(d_of(k));
        else if (r == 3) val = 64'd0;
        issue(k, val);
        wait_done(k);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(2);
    end

    idle(3);
    chk("scoreboard_empty", 0, 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_convert_module.md
BCD_CONVERT_MODULE -- requirements
Module: bcd_convert_module

Interface
REQ-001 Parameter DATA_W, default 8, binary input width (range 4..32).
REQ-002 Parameter DIGITS, default 3, number of BCD output digits (range 1..10).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  system clock; all state changes on rising edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 Start_Sig  input  1  request to convert Number_Data; sampled only in IDLE.
REQ-007 Number_Data  input  DATA_W  unsigned binary value; captured on the accepting edge.
REQ-008 Busy  output  1  high while a conversion is in progress.
REQ-009 Done_Sig  output  1  one-cycle pulse when a conversion completes.
REQ-010 Bcd_Data  output  4*DIGITS  result; digit i at bits [4i+3:4i], digit 0 = ones.
REQ-011 Overflow  output  1  result exceeded 10^DIGITS-1.
REQ-012 Digit_Blank  output  DIGITS  per-digit leading-zero blank mask for display drivers.

Function
REQ-013 Conversion SHALL use iterative shift-add-3 (double dabble), one input bit per clock, MSB first.
REQ-014 FSM states: IDLE, SHIFT. IDLE->SHIFT on Start_Sig=1; SHIFT->IDLE after DATA_W shift edges; no other transitions except reset.
REQ-015 On the accepting edge, Number_Data SHALL be loaded into a shift register, the BCD accumulator and overflow flag cleared, and the bit counter zeroed.
REQ-016 Each SHIFT edge: every accumulator digit >=5 gets +3, then {accumulator, shift register} shifts left by one.
REQ-017 Any 1 shifted out of the top digit's MSB SHALL set a sticky internal overflow flag.
REQ-018 On the last (DATA_W-th) SHIFT edge, Bcd_Data, Overflow and Digit_Blank SHALL be registered and Done_Sig driven high for exactly that following cycle.
REQ-019 Latency: Done_Sig high in the cycle starting DATA_W edges after the Start_Sig-sampling edge.
REQ-020 On overflow, Bcd_Data SHALL saturate to all digits = 9 and Overflow = 1; otherwise Overflow = 0.
REQ-021 Digit_Blank[i]=1 iff digit i and all higher digits are zero, for i >= 1; Digit_Blank[0] SHALL always be 0; all 0 when Overflow=1.
REQ-022 Busy SHALL be 1 exactly in SHIFT state and 0 in the Done_Sig cycle.
REQ-023 Start_Sig while Busy=1 SHALL be ignored with no effect on the running conversion.
REQ-024 Start_Sig high in the Done_Sig cycle SHALL be accepted (back-to-back, no dead cycle).
REQ-025 Bcd_Data, Overflow, Digit_Blank SHALL hold their last result until the next completion; never show intermediate values.
REQ-026 Number_Data changes after the accepting edge SHALL not affect the result in progress.

Reset
REQ-027 RST=1 at a clock edge SHALL force IDLE, Busy=0, Done_Sig=0, Bcd_Data=0, Overflow=0, Digit_Blank={DIGITS-1 ones, 0}.
REQ-028 RST SHALL take priority over Start_Sig in the same cycle; a conversion interrupted by reset SHALL produce no Done_Sig.

Structure
REQ-029 Shared package bcd_pkg SHALL hold the FSM state type, the BCD digit width constant (4) and the counter-width function (clog2).
REQ-030 One sub-module bcd_digit_adj (4-bit in, +3 if >=5, 4-bit out) SHALL be instantiated DIGITS times via generate.
REQ-031 Bit counter width SHALL be clog2(DATA_W+1); no divider or modulo operators permitted.

Verification
REQ-032 DATA_W=8,DIGITS=3: Number_Data=255, Start pulse -> Done after 8 cycles, Bcd_Data=0x255, Overflow=0, Digit_Blank=000.
REQ-033 DATA_W=8,DIGITS=3: Number_Data=0 -> Bcd_Data=0x000, Digit_Blank=110; Number_Data=7 -> 0x007, Digit_Blank=110.
REQ-034 DATA_W=8,DIGITS=2: Number_Data=200 -> Bcd_Data=0x99, Overflow=1, Digit_Blank=00.
REQ-035 DATA_W=16,DIGITS=5: 65535 then Start in Done cycle with 1234 -> 0x65535, then 0x01234 (Digit_Blank=10000) with no idle gap.
REQ-036 Start_Sig with new data at cycle 3 of a busy conversion -> ignored, original result unchanged; RST at cycle 4 of another conversion -> no Done_Sig, outputs at reset values.
